// File: rtl/maclaurin_job_scheduler_if.sv
// Requester/pipeline bundle for the Maclaurin job scheduler.
// The slave side is the scheduler. The master side is the requester front-ends
// together with the term datapath.
interface maclaurin_job_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] x_in;
    logic [NREQ*3-1:0] n_in;
    logic [NREQ-1:0]   gnt;
    logic              pipe_valid;
    logic [W-1:0]      pipe_x;
    logic [2:0]        pipe_k;
    logic              pipe_first;
    logic              pipe_last;
    logic              pipe_err;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;

    modport slave (
        input  req, x_in, n_in, pipe_err,
        output gnt, pipe_valid, pipe_x, pipe_k, pipe_first, pipe_last, done, err, busy
    );

    modport master (
        output req, x_in, n_in, pipe_err,
        input  gnt, pipe_valid, pipe_x, pipe_k, pipe_first, pipe_last, done, err, busy
    );
endinterface

// File: rtl/maclaurin_job_scheduler.sv
// Round-robin job scheduler in front of a shared fixed-latency Maclaurin term pipeline.
// It accepts one job (x, N) at a time and issues N terms back to back.
// A tag shift register follows each term to the pipeline output, where the owner
// receives a done or err pulse.
module maclaurin_job_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int LAT  = 5
) (
    input  logic clk,
    input  logic rst,
    maclaurin_job_scheduler_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [2:0]      k_q, k_d;
    logic [2:0]      lastk_q, lastk_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [W-1:0]    x_q, x_d;

    // Tag pipeline: stage LAT-1 lines up with pipe_err.
    logic [LAT-1:0]  tvld_q;
    logic [LAT-1:0]  tlast_q;
    logic [OW-1:0]   town_q [LAT];

    logic            issuing;
    logic            is_last;
    logic            grant_ok;
    logic            found;
    logic            abort;
    logic            err_hit;
    logic [OW-1:0]   err_own;
    logic [OW-1:0]   gidx;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;

    // Requester index at a given offset from base, wrapping at NREQ.
    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int off);
        return OW'((int'(base) + off) % NREQ);
    endfunction

    assign issuing  = (state_q == ISSUE);
    assign is_last  = (k_q == lastk_q);
    assign eligible = bus.req & ~pending_q;
    assign err_hit  = tvld_q[LAT-1] & bus.pipe_err & ~rst;
    assign err_own  = town_q[LAT-1];
    // An error on the active job's owner aborts the job and blocks this cycle's grant.
    assign abort    = err_hit & issuing & (err_own == owner_q);
    assign grant_ok = ~rst & ((state_q == IDLE) | (issuing & is_last & ~abort));

    // Round-robin search that starts at the pointer.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && eligible[rr_idx(ptr_q, off)]) begin
                found = 1'b1;
                gidx  = rr_idx(ptr_q, off);
            end
        end
    end

    // One-hot grant, plus completion/abort decode from the tag at the last stage.
    always_comb begin
        gnt  = '0;
        done = '0;
        err  = '0;
        if (found && grant_ok) begin
            gnt[gidx] = 1'b1;
        end
        for (int o = 0; o < NREQ; o++) begin
            done[o] = ~rst & tvld_q[LAT-1] & tlast_q[LAT-1] & ~bus.pipe_err
                      & (town_q[LAT-1] == OW'(o));
            err[o]  = err_hit & (err_own == OW'(o));
        end
    end

    // FSM, term counter, job latch, pointer and pending next-state.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lastk_d = lastk_q;
        owner_d = owner_q;
        x_d     = x_q;
        ptr_d   = ptr_q;
        if (issuing) begin
            if (abort || is_last) begin
                state_d = IDLE;
            end else begin
                k_d = k_q + 3'd1;
            end
        end
        if (|gnt) begin
            state_d = ISSUE;
            k_d     = 3'd0;
            owner_d = gidx;
            x_d     = bus.x_in[int'(gidx)*W +: W];
            // N=0 wraps to a last index of 7, which gives eight terms.
            lastk_d = bus.n_in[int'(gidx)*3 +: 3] - 3'd1;
            ptr_d   = rr_idx(gidx, 1);
        end
        pending_d = (pending_q & ~(done | err)) | gnt;
    end

    // Control and job registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            pending_q <= '0;
            k_q       <= '0;
            lastk_q   <= '0;
            owner_q   <= '0;
            x_q       <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            k_q       <= k_d;
            lastk_q   <= lastk_d;
            owner_q   <= owner_d;
            x_q       <= x_d;
        end
    end

    // Tag valid shift. Tags of an erroring owner are killed as they move.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvld_q <= '0;
        end else begin
            tvld_q[0] <= issuing & ~(err_hit & (err_own == owner_q));
            for (int j = 1; j < LAT; j++) begin
                tvld_q[j] <= tvld_q[j-1] & ~(err_hit & (err_own == town_q[j-1]));
            end
        end
    end

    // Tag payload shift. It is only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        tlast_q[0] <= is_last;
        town_q[0]  <= owner_q;
        for (int j = 1; j < LAT; j++) begin
            tlast_q[j] <= tlast_q[j-1];
            town_q[j]  <= town_q[j-1];
        end
    end

    assign bus.gnt        = gnt;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.pipe_valid = issuing;
    assign bus.pipe_x     = x_q;
    assign bus.pipe_k     = k_q;
    assign bus.pipe_first = issuing & (k_q == 3'd0);
    assign bus.pipe_last  = issuing & is_last;
    assign bus.busy       = issuing | (|tvld_q);
endmodule
